// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receive-path types
package uart_pkg;

  localparam int UART_DATA_W = 8;

  // One buffered character plus its parity status (perr=1: parity failed or never reported)
  typedef struct packed {
    logic                   perr;
    logic [UART_DATA_W-1:0] data;
  } rx_entry_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// rtl/uart_fifo_mem.sv - simple dual-port register array, sync write, async read
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int W     = UART_DATA_W + 1,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // Storage is deliberately never cleared; occupancy tracking lives in the FIFO controller
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - first-word-fall-through receive buffer behind the UART receiver
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int DEPTH  = 16
) (
  input  logic                      clk,
  input  logic                      Reset,
  input  logic                      rx_done_tick,
  input  logic [DATA_W-1:0]         rx_data,
  input  logic                      par_ok,
  input  logic                      rd_en,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      rd_perr,
  output logic                      empty,
  output logic                      full,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overrun,
  input  logic                      clr_overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     cnt_q;
  logic            par_pending;
  logic            rd_accept;
  logic            wr_accept;
  logic            ovr_event;
  logic            wr_perr;
  logic [DATA_W:0] wr_word;
  logic [DATA_W:0] rd_word;

  // Flags come only from the registered count, so rd_en never reaches an output combinationally
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == FULL_CNT);
  assign count = cnt_q;

  // A pop at full frees the slot the same cycle, so a simultaneous write is still accepted
  assign rd_accept = rd_en & ~empty;
  assign wr_accept = rx_done_tick & (~full | rd_accept);
  assign ovr_event = rx_done_tick & full & ~rd_accept;

  // A par_ok coincident with the done tick still belongs to the character being written
  assign wr_perr = ~(par_pending | par_ok);
  assign wr_word = {wr_perr, rx_data};

  uart_fifo_mem #(
    .W     (DATA_W + 1),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_accept),
    .waddr (wr_ptr),
    .wdata (wr_word),
    .raddr (rd_ptr),
    .rdata (rd_word)
  );

  assign rd_perr = rd_word[DATA_W];
  assign rd_data = rd_word[DATA_W-1:0];

  // Remember a parity pass until the character it belongs to completes (even if that character is dropped)
  always_ff @(posedge clk) begin
    if (Reset) begin
      par_pending <= 1'b0;
    end else if (rx_done_tick) begin
      par_pending <= 1'b0;
    end else if (par_ok) begin
      par_pending <= 1'b1;
    end
  end

  // Pointers roll over naturally at DEPTH; the count tells full and empty apart
  always_ff @(posedge clk) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_accept) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  // Occupancy moves only when exactly one of write/read is accepted
  always_ff @(posedge clk) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      case ({wr_accept, rd_accept})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Sticky drop indicator; a new drop outranks a same-cycle clear
  always_ff @(posedge clk) begin
    if (Reset) begin
      overrun <= 1'b0;
    end else if (ovr_event) begin
      overrun <= 1'b1;
    end else if (clr_overrun) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - scoreboard bench for uart_rx_fifo
module tb_uart_rx_fifo;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       Reset;
  logic       rx_done_tick;
  logic [7:0] rx_data;
  logic       par_ok;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_perr;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overrun;
  logic       clr_overrun;

  int total = 0;
  int bad   = 0;

  rx_entry_t sb[$];

  uart_rx_fifo #(.DATA_W(8), .DEPTH(16)) dut (
    .clk          (clk),
    .Reset        (Reset),
    .rx_done_tick (rx_done_tick),
    .rx_data      (rx_data),
    .par_ok       (par_ok),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_perr      (rd_perr),
    .empty        (empty),
    .full         (full),
    .count        (count),
    .overrun      (overrun),
    .clr_overrun  (clr_overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic pr, input logic wr, input logic [7:0] d,
                       input logic rd, input logic clr);
    par_ok = pr; rx_done_tick = wr; rx_data = d; rd_en = rd; clr_overrun = clr;
    @(posedge clk); #1;
    par_ok = 0; rx_done_tick = 0; rd_en = 0; clr_overrun = 0;
  endtask

  task automatic expect_entry(input logic perr, input logic [7:0] d);
    rx_entry_t e;
    e.perr = perr;
    e.data = d;
    sb.push_back(e);
  endtask

  // Monitor: every accepted pop is compared with the oldest expected entry
  always @(negedge clk) begin
    if (!Reset && rd_en && !empty) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pop_unexpected: got %0h expected none", {rd_perr, rd_data});
      end else begin
        rx_entry_t e;
        e = sb.pop_front();
        check("pop_entry", {23'd0, rd_perr, rd_data}, {23'd0, e.perr, e.data});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    Reset = 1; rx_done_tick = 0; rx_data = 0; par_ok = 0; rd_en = 0; clr_overrun = 0;
    @(posedge clk); @(posedge clk); #1;
    Reset = 0;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_overrun", overrun, 0);

    // single character with parity pass
    drive(1, 0, 8'h00, 0, 0);
    drive(0, 1, 8'hA5, 0, 0); expect_entry(0, 8'hA5);
    check("single_empty", empty, 0);
    check("single_count", count, 1);
    check("single_data", rd_data, 8'hA5);
    check("single_perr", rd_perr, 0);
    drive(0, 0, 8'h00, 1, 0);
    check("single_pop_empty", empty, 1);
    check("single_pop_count", count, 0);

    // pop while empty is ignored
    drive(0, 0, 8'h00, 1, 0);
    check("empty_pop_count", count, 0);

    // parity error, then a good one, then par_ok coincident with the tick
    drive(0, 1, 8'h3C, 0, 0); expect_entry(1, 8'h3C);
    check("perr_head", rd_perr, 1);
    drive(1, 0, 8'h00, 0, 0);
    drive(0, 1, 8'h3D, 0, 0); expect_entry(0, 8'h3D);
    drive(1, 1, 8'h5A, 0, 0); expect_entry(0, 8'h5A);
    check("perr_count", count, 3);
    repeat (3) drive(0, 0, 8'h00, 1, 0);
    check("perr_drained", empty, 1);

    // fill and overrun
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, 8'(i), 0, 0); expect_entry(1, 8'(i));
    end
    check("fill_full", full, 1);
    check("fill_count", count, 16);
    check("fill_no_ovr", overrun, 0);
    drive(0, 1, 8'hFF, 0, 0);
    check("ovr_set", overrun, 1);
    check("ovr_count", count, 16);
    drive(0, 1, 8'hFE, 0, 1);
    check("ovr_set_wins", overrun, 1);
    repeat (16) drive(0, 0, 8'h00, 1, 0);
    check("ovr_drained", empty, 1);
    check("ovr_held", overrun, 1);
    drive(0, 0, 8'h00, 0, 1);
    check("ovr_cleared", overrun, 0);

    // simultaneous read and write at full
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, 8'h00, 0, 0);
      drive(0, 1, 8'(i), 0, 0); expect_entry(0, 8'(i));
    end
    check("sim_head0", rd_data, 8'h00);
    drive(0, 1, 8'h77, 1, 0); expect_entry(1, 8'h77);
    check("sim_count", count, 16);
    check("sim_overrun", overrun, 0);
    check("sim_head1", rd_data, 8'h01);
    repeat (16) drive(0, 0, 8'h00, 1, 0);
    check("sim_drained", empty, 1);

    // interleaved write/read pairs wrap the pointers
    for (int i = 0; i < 40; i++) begin
      logic p;
      p = i[0];
      drive(p, 1, 8'(8'h80 + i), 0, 0); expect_entry(~p, 8'(8'h80 + i));
      check("wrap_count_w", count, 1);
      drive(0, 0, 8'h00, 1, 0);
      check("wrap_count_r", count, 0);
    end

    // reset mid-operation with parity pending
    for (int i = 0; i < 5; i++) drive(1, 1, 8'(8'h10 + i), 0, 0);
    drive(1, 0, 8'h00, 0, 0);
    check("mid_count_pre", count, 5);
    Reset = 1;
    @(posedge clk); #1;
    Reset = 0;
    check("mid_count", count, 0);
    check("mid_empty", empty, 1);
    check("mid_overrun", overrun, 0);
    drive(0, 1, 8'h42, 0, 0); expect_entry(1, 8'h42);
    check("mid_perr", rd_perr, 1);
    drive(0, 0, 8'h00, 1, 0);
    check("mid_final_empty", empty, 1);

    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
